// File: rtl/eth_frame_fifo.sv
// Store-and-forward Ethernet RX frame FIFO: whole frames are released only after an error-free last beat.
// Latency: last beat written at edge N (FIFO empty) -> rd_valid high after edge N+1; 1 beat/clk sustained.
// Backpressure: none on the write side (overflowing frames are dropped); read side is valid/ready.
// Optional: define ETH_FIFO_STATS_EN to add saturating frames_ok / frames_drop counters.
module eth_frame_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2048,
  parameter int AF_THRESH  = 1536
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     wr_valid,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_last,
  input  logic                     wr_err,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     almost_full,
`ifdef ETH_FIFO_STATS_EN
  output logic [15:0]              frames_ok,
  output logic [15:0]              frames_drop,
`endif
  output logic                     drop_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE     = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);

  typedef enum logic {ACCEPT = 1'b0, DISCARD = 1'b1} wr_state_t;

  // Storage: each word carries the end-of-frame flag alongside the data.
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, commit_ptr_nxt;
  wr_state_t     state, state_nxt;
  logic          ram_we;
  logic          drop_nxt;
  logic          commit_evt;
  logic          full;
  logic          avail;
  logic          load;
  logic [DATA_WIDTH:0] rd_word;

  assign fill        = wr_ptr - rd_ptr;
  assign full        = (fill == DEPTH_P);
  assign almost_full = (fill >= AF_P);
  assign avail       = (commit_ptr != rd_ptr);
  assign load        = avail && (!rd_valid || rd_ready);
  assign rd_word     = mem[rd_ptr[AW-1:0]];

  // Write-side FSM state and pointer registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ACCEPT;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      drop_pulse <= drop_nxt;
    end
  end

  // Write-side next state: speculative write, commit on good last beat, rewind on error/overflow.
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    ram_we         = 1'b0;
    drop_nxt       = 1'b0;
    commit_evt     = 1'b0;
    if (wr_valid) begin
      case (state)
        ACCEPT: begin
          if (!full) begin
            ram_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + ONE;
            if (wr_last) begin
              if (wr_err) begin
                wr_ptr_nxt = commit_ptr;
                drop_nxt   = 1'b1;
              end else begin
                commit_ptr_nxt = wr_ptr + ONE;
                commit_evt     = 1'b1;
              end
            end
          end else begin
            // Overflow: throw the partial frame away; skip its tail unless this was the tail.
            wr_ptr_nxt = commit_ptr;
            drop_nxt   = 1'b1;
            if (!wr_last) state_nxt = DISCARD;
          end
        end
        DISCARD: begin
          if (wr_last) state_nxt = ACCEPT;
        end
        default: state_nxt = ACCEPT;
      endcase
    end
  end

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
  end

  // Show-ahead output register: refill whenever empty or being consumed and committed data waits.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else if (load) begin
      rd_ptr   <= rd_ptr + ONE;
      rd_valid <= 1'b1;
      rd_data  <= rd_word[DATA_WIDTH-1:0];
      rd_last  <= rd_word[DATA_WIDTH];
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

`ifdef ETH_FIFO_STATS_EN
  // Saturating frame statistics.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frames_ok   <= '0;
      frames_drop <= '0;
    end else begin
      if (commit_evt && frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
      if (drop_nxt && frames_drop != 16'hFFFF) frames_drop <= frames_drop + 16'd1;
    end
  end
`endif

endmodule
